output_collector: RTL
=====================

Name: output_collector

Overview:
Parametrised successor to the single-router output bus. Collects spike packets leaving the core grid on NUM_CHANNELS edge routers, each exposed as a first-word-fall-through buffer with empty/ren. Arbitrates round-robin, stamps each packet with a global tick count and its channel, and buffers results in an output FIFO with a valid/ready interface to the host/DMA side. Backpressure or drop-on-full is selectable; drops are counted and flagged.

Parameters:
NUM_CHANNELS, 4, number of edge router channels (>=1)
NUM_AXONS, 256, axon count; sets index field width AW=$clog2(NUM_AXONS)
NUM_TICKS, 16, tick-offset range; sets TW=$clog2(NUM_TICKS)
NUM_OUTPUTS, 256, output neuron count (<=NUM_AXONS); OW=$clog2(NUM_OUTPUTS)
FIFO_DEPTH, 16, output FIFO entries; power of 2, >=2
TICK_WIDTH, 16, global tick counter width
DROP_ON_FULL, 0, 0=backpressure, 1=pop and discard when FIFO full
DROP_CNT_WIDTH, 16, drop counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle global tick pulse
clear_errors  input  1  synchronous clear of drop_count and overflow
ch_empty  input  NUM_CHANNELS  per-channel buffer empty
ch_ren  output  NUM_CHANNELS  per-channel read enable (pop at clock edge)
ch_data  input  NUM_CHANNELS*(AW+TW)  packed channel heads; channel c at [c*(AW+TW) +: AW+TW]
out_valid  output  1  output FIFO non-empty
out_ready  input  1  consumer accepts head
out_data  output  TICK_WIDTH+CW+OW  {tick_stamp, channel, index}; CW=max(1,$clog2(NUM_CHANNELS))
fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
drop_count  output  DROP_CNT_WIDTH  dropped packets, saturating
overflow  output  1  sticky drop flag

Behaviour:
- Reset: ch_ren=0, out_valid=0, out_data=0, fifo_count=0, drop_count=0, overflow=0, tick counter=0, RR pointer=0, FIFO pointers=0.
- Channel heads are FWFT: ch_data valid while ch_empty=0; ch_ren high at an edge pops one entry. ch_ren is combinational from state/inputs; at most one bit high per cycle; never high on an empty channel.
- Field extraction: index = ch_data[c][AW+TW-1:TW], low OW bits kept; tick-offset bits discarded.
- Arbitration: search channels starting at RR pointer, wrapping; first non-empty channel c is granted. After a grant, pointer <= (c+1) mod NUM_CHANNELS. No grant leaves pointer unchanged.
- Accept condition: space = (fifo_count<FIFO_DEPTH) or (out_valid and out_ready).
  - space: ch_ren[c]=1; {tick_cnt, c, index} written at same edge (zero added latency; out_valid rises the next cycle when FIFO was empty).
  - no space, DROP_ON_FULL=0: no ch_ren; pointer held.
  - no space, DROP_ON_FULL=1: ch_ren[c]=1, packet discarded, drop_count+1 (saturates at all-ones), overflow<=1, pointer advances.
- Output FIFO: out_data = head, registered storage; pop on out_valid and out_ready. Simultaneous push and pop: count unchanged, both performed, including when full.
- Tick: tick=1 increments tick counter (wraps at 2^TICK_WIDTH); a packet accepted that cycle is stamped with the pre-increment value.
- clear_errors: drop_count<=0, overflow<=0; a drop in the same cycle takes priority (count=1, overflow=1).
- Reset mid-operation: FIFO contents discarded, all state to reset values immediately; no ch_ren during reset.
- Throughput: one packet per cycle sustained when space available.

Test Plan:
- Single packet: channel 2 presents index 0x5A, offset 3, tick count 7 -> ch_ren=4'b0100 for one cycle; next cycle out_valid=1, out_data={16'd7, 2'd2, 8'h5A}.
- Fairness: all 4 channels hold 3 packets each, out_ready=1 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; 12 outputs in 12 consecutive cycles.
- Backpressure (DROP_ON_FULL=0, depth 16): out_ready=0, channel 0 holds 20 packets -> exactly 16 pops, fifo_count=16, ch_ren=0 after; raising out_ready drains in order with no loss, drop_count=0.
- Drop mode (DROP_ON_FULL=1): same stimulus -> 16 stored, 4 discarded, drop_count=4, overflow=1; clear_errors pulse -> both 0.
- Full with simultaneous pop: count=16, out_ready=1, channel 1 non-empty -> push and pop same cycle, count stays 16, no drop.
- Tick wrap and reset: TICK_WIDTH=4, 16 tick pulses -> stamp returns to 0; assert reset with 5 entries queued -> out_valid=0, fifo_count=0 asynchronously.

Source files
------------

// File: rtl/output_collector.sv
`default_nettype none
// ============================================================================
// Module      : output_collector
// Description : Round-robin collector of edge-router spike packets into a
//               tick-stamped output FIFO with valid/ready drain.
// Revision    : 1.0 - initial release
// ============================================================================
module output_collector #(
    parameter int NUM_CHANNELS   = 4,
    parameter int NUM_AXONS      = 256,
    parameter int NUM_TICKS      = 16,
    parameter int NUM_OUTPUTS    = 256,
    parameter int FIFO_DEPTH     = 16,
    parameter int TICK_WIDTH     = 16,
    parameter int DROP_ON_FULL   = 0,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int AW    = $clog2(NUM_AXONS),
    localparam int TW    = $clog2(NUM_TICKS),
    localparam int OW    = $clog2(NUM_OUTPUTS),
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int DW    = AW + TW,
    localparam int OUT_W = TICK_WIDTH + CW + OW,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         clear_errors,
    input  logic [NUM_CHANNELS-1:0]      ch_empty,
    output logic [NUM_CHANNELS-1:0]      ch_ren,
    input  logic [NUM_CHANNELS*DW-1:0]   ch_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [CNT_W-1:0]             fifo_count,
    output logic [DROP_CNT_WIDTH-1:0]    drop_count,
    output logic                         overflow
);

    localparam int PW = CNT_W - 1;

    logic [CW-1:0]             r_rr_ptr;
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic [TICK_WIDTH-1:0]     r_tick;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic                      r_overflow;
    logic [OUT_W-1:0]          r_mem [FIFO_DEPTH];

    logic [OW-1:0]             w_ch_index [NUM_CHANNELS];
    logic [CW-1:0]             w_grant;
    logic [CW-1:0]             w_next_ptr;
    logic [31:0]               w_scan;
    logic                      w_grant_valid;
    logic                      w_pop;
    logic                      w_space;
    logic                      w_push;
    logic                      w_drop;

    // Only the low OW index bits are carried; tick-offset bits are dropped.
    logic w_unused_ch_bits;
    assign w_unused_ch_bits = ^ch_data;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_index
        assign w_ch_index[g] = ch_data[g*DW + TW +: OW];
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_scan        = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_scan = (32'(r_rr_ptr) + 32'(i)) % 32'(NUM_CHANNELS);
            if (!w_grant_valid && !ch_empty[w_scan[CW-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant       = w_scan[CW-1:0];
            end
        end
    end

    assign w_next_ptr = (w_grant == CW'(NUM_CHANNELS - 1)) ? '0 : w_grant + 1'b1;
    assign w_pop      = (r_count != '0) && out_ready;
    assign w_space    = (r_count != CNT_W'(FIFO_DEPTH)) || w_pop;
    assign w_push     = w_grant_valid && w_space && !reset;
    assign w_drop     = w_grant_valid && !w_space && (DROP_ON_FULL != 0) && !reset;

    always_comb begin
        ch_ren = '0;
        if (w_push || w_drop) begin
            ch_ren[w_grant] = 1'b1;
        end
    end

    // Storage is not reset; occupancy gates everything visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_tick, w_grant, w_ch_index[w_grant]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tick     <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (tick) begin
                r_tick <= r_tick + 1'b1;
            end
            if (w_push || w_drop) begin
                r_rr_ptr <= w_next_ptr;
            end
            // A drop in the same cycle as a clear wins.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clear_errors) begin
                    r_drop_cnt <= DROP_CNT_WIDTH'(1);
                end else if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end else if (clear_errors) begin
                r_drop_cnt <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign drop_count = r_drop_cnt;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
